// File: rtl/cpuf_pkg.sv
// rtl/cpuf_pkg.sv - shared opcode, ALU operation and sequencer state definitions
package cpuf_pkg;

   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_LDB = 4'b0100;
   localparam logic [3:0] OP_LDA = 4'b1000;
   localparam logic [3:0] OP_JMP = 4'b1001;
   localparam logic [3:0] OP_DIV = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1100;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_MUL = 2'b10;
   localparam logic [1:0] ALU_DIV = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_F_ADDR,
      S_F_WAIT,
      S_F_IR,
      S_DECODE,
      S_X_ADDR,
      S_X_WAIT,
      S_X_LOAD,
      S_X_ALU,
      S_X_MDSTART,
      S_X_MDWAIT,
      S_X_JMP,
      S_HALT
   } seq_state_t;

   // Opcodes that fetch an operand from RAM before executing.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LDA) || (op == OP_LDB) || (op == OP_ADD) ||
             (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - 8-bit loadable down-counter with zero flag
// Shared between the RAM latency waits and the MUL/DIV watchdog.
module seq_wait_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_load,
   input  logic [7:0] i_value,
   input  logic       i_en,
   output logic       o_zero
);

   logic [7:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 8'd0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_en && (r_count != 8'd0)) begin
         r_count <= r_count - 8'd1;
      end
   end

   assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute control FSM for the 8-bit accumulator CPU
// Strobes are decoded from the current state; retired/illegal/fault are registered.
module instr_sequencer
   import cpuf_pkg::*;
#(
   parameter int RAM_LAT    = 1,
   parameter int MD_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_run,
   input  logic [3:0] i_opcode,
   input  logic       i_alu_done,
   output logic       o_pc_out,
   output logic       o_pc_inc,
   output logic       o_pc_load,
   output logic       o_ir_addr_out,
   output logic       o_mar_load,
   output logic       o_ram_rd,
   output logic       o_ir_load,
   output logic       o_a_load,
   output logic       o_b_load,
   output logic       o_alu_en,
   output logic       o_alu_start,
   output logic [1:0] o_alu_op,
   output logic       o_halted,
   output logic       o_illegal,
   output logic       o_fault,
   output logic [7:0] o_retired
);

   // Timer counts down to zero, so a load of N-1 yields N wait cycles.
   localparam logic [7:0] RAM_WAIT_INIT = 8'(RAM_LAT - 1);
   localparam logic [7:0] MD_WAIT_INIT  = 8'(MD_TIMEOUT - 1);

   seq_state_t r_state;
   seq_state_t w_next;
   seq_state_t w_boundary_next;

   logic       r_illegal;
   logic       r_fault;
   logic [7:0] r_retired;

   logic       w_tmr_load;
   logic [7:0] w_tmr_value;
   logic       w_tmr_en;
   logic       w_tmr_zero;
   logic       w_retire;
   logic       w_set_illegal;
   logic       w_set_fault;

   seq_wait_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_tmr_load),
      .i_value (w_tmr_value),
      .i_en    (w_tmr_en),
      .o_zero  (w_tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_illegal <= 1'b0;
         r_fault   <= 1'b0;
         r_retired <= 8'd0;
      end else begin
         r_state <= w_next;
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
         if (w_set_fault) begin
            r_fault <= 1'b1;
         end
         if (w_retire) begin
            r_retired <= r_retired + 8'd1;
         end
      end
   end

   // run is only looked at here, in the last cycle of an instruction.
   assign w_boundary_next = i_run ? S_F_ADDR : S_IDLE;

   always_comb begin
      w_next        = r_state;
      o_pc_out      = 1'b0;
      o_pc_inc      = 1'b0;
      o_pc_load     = 1'b0;
      o_ir_addr_out = 1'b0;
      o_mar_load    = 1'b0;
      o_ram_rd      = 1'b0;
      o_ir_load     = 1'b0;
      o_a_load      = 1'b0;
      o_b_load      = 1'b0;
      o_alu_en      = 1'b0;
      o_alu_start   = 1'b0;
      o_alu_op      = ALU_ADD;
      w_tmr_load    = 1'b0;
      w_tmr_value   = 8'd0;
      w_tmr_en      = 1'b0;
      w_retire      = 1'b0;
      w_set_illegal = 1'b0;
      w_set_fault   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_run) begin
               w_next = S_F_ADDR;
            end
         end
         S_F_ADDR: begin
            o_pc_out    = 1'b1;
            o_mar_load  = 1'b1;
            w_tmr_load  = 1'b1;
            w_tmr_value = RAM_WAIT_INIT;
            w_next      = S_F_WAIT;
         end
         S_F_WAIT: begin
            o_ram_rd = 1'b1;
            w_tmr_en = 1'b1;
            if (w_tmr_zero) begin
               w_next = S_F_IR;
            end
         end
         S_F_IR: begin
            o_ir_load = 1'b1;
            o_pc_inc  = 1'b1;
            w_next    = S_DECODE;
         end
         S_DECODE: begin
            if (is_mem_op(i_opcode)) begin
               w_next = S_X_ADDR;
            end else if (i_opcode == OP_JMP) begin
               w_next = S_X_JMP;
            end else if (i_opcode == OP_HLT) begin
               w_retire = 1'b1;
               w_next   = S_HALT;
            end else begin
               w_set_illegal = 1'b1;
               w_retire      = 1'b1;
               w_next        = w_boundary_next;
            end
         end
         S_X_ADDR: begin
            o_ir_addr_out = 1'b1;
            o_mar_load    = 1'b1;
            w_tmr_load    = 1'b1;
            w_tmr_value   = RAM_WAIT_INIT;
            w_next        = S_X_WAIT;
         end
         S_X_WAIT: begin
            o_ram_rd = 1'b1;
            w_tmr_en = 1'b1;
            if (w_tmr_zero) begin
               if ((i_opcode == OP_LDA) || (i_opcode == OP_LDB)) begin
                  w_next = S_X_LOAD;
               end else if ((i_opcode == OP_ADD) || (i_opcode == OP_SUB)) begin
                  w_next = S_X_ALU;
               end else begin
                  w_next = S_X_MDSTART;
               end
            end
         end
         S_X_LOAD: begin
            o_a_load = (i_opcode == OP_LDA);
            o_b_load = (i_opcode != OP_LDA);
            w_retire = 1'b1;
            w_next   = w_boundary_next;
         end
         S_X_ALU: begin
            o_alu_en = 1'b1;
            o_b_load = 1'b1;
            o_alu_op = (i_opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
            w_retire = 1'b1;
            w_next   = w_boundary_next;
         end
         S_X_MDSTART: begin
            // alu_done is deliberately not looked at in the start cycle.
            o_alu_start = 1'b1;
            o_alu_op    = (i_opcode == OP_DIV) ? ALU_DIV : ALU_MUL;
            w_tmr_load  = 1'b1;
            w_tmr_value = MD_WAIT_INIT;
            w_next      = S_X_MDWAIT;
         end
         S_X_MDWAIT: begin
            if (i_alu_done) begin
               o_b_load = 1'b1;
               w_retire = 1'b1;
               w_next   = w_boundary_next;
            end else if (w_tmr_zero) begin
               w_set_fault = 1'b1;
               w_next      = S_HALT;
            end else begin
               w_tmr_en = 1'b1;
            end
         end
         S_X_JMP: begin
            o_ir_addr_out = 1'b1;
            o_pc_load     = 1'b1;
            w_retire      = 1'b1;
            w_next        = w_boundary_next;
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign o_halted  = (r_state == S_HALT);
   assign o_illegal = r_illegal;
   assign o_fault   = r_fault;
   assign o_retired = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       run;
   logic [3:0] opcode;
   logic       alu_done;

   logic       d1_pc_out, d1_pc_inc, d1_pc_load, d1_ir_addr_out, d1_mar_load, d1_ram_rd;
   logic       d1_ir_load, d1_a_load, d1_b_load, d1_alu_en, d1_alu_start;
   logic [1:0] d1_alu_op;
   logic       d1_halted, d1_illegal, d1_fault;
   logic [7:0] d1_retired;

   logic       d3_pc_out, d3_pc_inc, d3_pc_load, d3_ir_addr_out, d3_mar_load, d3_ram_rd;
   logic       d3_ir_load, d3_a_load, d3_b_load, d3_alu_en, d3_alu_start;
   logic [1:0] d3_alu_op;
   logic       d3_halted, d3_illegal, d3_fault;
   logic [7:0] d3_retired;

   // Strobe order: pc_out pc_inc pc_load ir_addr_out mar_load ram_rd ir_load a_load b_load alu_en alu_start
   logic [10:0] s1;
   assign s1 = {d1_pc_out, d1_pc_inc, d1_pc_load, d1_ir_addr_out, d1_mar_load, d1_ram_rd,
                d1_ir_load, d1_a_load, d1_b_load, d1_alu_en, d1_alu_start};

   localparam logic [10:0] ST_NONE  = 11'b00000000000;
   localparam logic [10:0] ST_FADDR = 11'b10001000000;
   localparam logic [10:0] ST_RD    = 11'b00000100000;
   localparam logic [10:0] ST_FIR   = 11'b01000010000;
   localparam logic [10:0] ST_XADDR = 11'b00011000000;
   localparam logic [10:0] ST_ALOAD = 11'b00000001000;
   localparam logic [10:0] ST_BLOAD = 11'b00000000100;
   localparam logic [10:0] ST_ALU   = 11'b00000000110;
   localparam logic [10:0] ST_START = 11'b00000000001;
   localparam logic [10:0] ST_JMP   = 11'b00110000000;

   int n_checks = 0;
   int n_fail   = 0;
   logic [10:0] ev [16];

   always #5 clk = ~clk;

   instr_sequencer #(.RAM_LAT(1), .MD_TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .i_run(run), .i_opcode(opcode), .i_alu_done(alu_done),
      .o_pc_out(d1_pc_out), .o_pc_inc(d1_pc_inc), .o_pc_load(d1_pc_load),
      .o_ir_addr_out(d1_ir_addr_out), .o_mar_load(d1_mar_load), .o_ram_rd(d1_ram_rd),
      .o_ir_load(d1_ir_load), .o_a_load(d1_a_load), .o_b_load(d1_b_load),
      .o_alu_en(d1_alu_en), .o_alu_start(d1_alu_start), .o_alu_op(d1_alu_op),
      .o_halted(d1_halted), .o_illegal(d1_illegal), .o_fault(d1_fault), .o_retired(d1_retired)
   );

   instr_sequencer #(.RAM_LAT(3), .MD_TIMEOUT(16)) dut3 (
      .clk(clk), .reset(reset), .i_run(run), .i_opcode(opcode), .i_alu_done(alu_done),
      .o_pc_out(d3_pc_out), .o_pc_inc(d3_pc_inc), .o_pc_load(d3_pc_load),
      .o_ir_addr_out(d3_ir_addr_out), .o_mar_load(d3_mar_load), .o_ram_rd(d3_ram_rd),
      .o_ir_load(d3_ir_load), .o_a_load(d3_a_load), .o_b_load(d3_b_load),
      .o_alu_en(d3_alu_en), .o_alu_start(d3_alu_start), .o_alu_op(d3_alu_op),
      .o_halted(d3_halted), .o_illegal(d3_illegal), .o_fault(d3_fault), .o_retired(d3_retired)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at cycle 0 (S_IDLE); the next tick is cycle 1.
   task automatic do_reset(input logic [3:0] op, input logic r);
      reset    = 1'b1;
      run      = r;
      opcode   = op;
      alu_done = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   task automatic check_trace(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk($sformatf("%s_c%0d", tag, i + 1), {21'd0, s1}, {21'd0, ev[i]});
      end
   endtask

   initial begin
      logic [10:0] rdv;
      logic        bor;
      logic        por;
      logic [10:0] sor;
      int          hcnt;

      reset = 1'b1; run = 1'b0; opcode = 4'b0000; alu_done = 1'b0;

      // Reset state
      do_reset(4'b1000, 1'b1);
      chk("rst_strobes", {21'd0, s1}, 32'd0);
      chk("rst_halted", {31'd0, d1_halted}, 32'd0);
      chk("rst_illegal", {31'd0, d1_illegal}, 32'd0);
      chk("rst_fault", {31'd0, d1_fault}, 32'd0);
      chk("rst_retired", {24'd0, d1_retired}, 32'd0);
      chk("rst_alu_op", {30'd0, d1_alu_op}, 32'd0);

      // LDA, then next fetch on cycle 8
      ev[0] = ST_FADDR; ev[1] = ST_RD; ev[2] = ST_FIR; ev[3] = ST_NONE;
      ev[4] = ST_XADDR; ev[5] = ST_RD; ev[6] = ST_ALOAD; ev[7] = ST_FADDR;
      check_trace("lda", 8);
      chk("lda_retired", {24'd0, d1_retired}, 32'd1);

      // ADD and SUB
      ev[6] = ST_ALU;
      do_reset(4'b0010, 1'b1);
      check_trace("add", 7);
      chk("add_alu_op", {30'd0, d1_alu_op}, 32'd0);
      do_reset(4'b0001, 1'b1);
      check_trace("sub", 7);
      chk("sub_alu_op", {30'd0, d1_alu_op}, 32'd1);

      // MUL with done pulse in the start cycle (ignored) and 3 cycles later
      do_reset(4'b1100, 1'b1);
      repeat (7) tick();
      chk("mul_start", {21'd0, s1}, {21'd0, ST_START});
      chk("mul_alu_op", {30'd0, d1_alu_op}, 32'd2);
      alu_done = 1'b1;
      #1;
      chk("mul_done_at_start", {21'd0, s1}, {21'd0, ST_START});
      tick();
      alu_done = 1'b0;
      #1;
      chk("mul_c8", {21'd0, s1}, {21'd0, ST_NONE});
      tick();
      tick();
      alu_done = 1'b1;
      #1;
      chk("mul_done_bload", {21'd0, s1}, {21'd0, ST_BLOAD});
      tick();
      alu_done = 1'b0;
      #1;
      chk("mul_next_fetch", {21'd0, s1}, {21'd0, ST_FADDR});
      chk("mul_retired", {24'd0, d1_retired}, 32'd1);

      // DIV with no done: watchdog
      do_reset(4'b1010, 1'b1);
      bor = 1'b0;
      repeat (7) begin
         tick();
         bor = bor | d1_b_load;
      end
      chk("div_alu_op", {30'd0, d1_alu_op}, 32'd3);
      repeat (16) begin
         tick();
         bor = bor | d1_b_load;
      end
      chk("div_c23_fault", {31'd0, d1_fault}, 32'd0);
      chk("div_c23_halted", {31'd0, d1_halted}, 32'd0);
      tick();
      bor = bor | d1_b_load;
      chk("div_to_fault", {31'd0, d1_fault}, 32'd1);
      chk("div_to_halted", {31'd0, d1_halted}, 32'd1);
      chk("div_to_no_bload", {31'd0, bor}, 32'd0);
      chk("div_to_retired", {24'd0, d1_retired}, 32'd0);

      // JMP
      do_reset(4'b1001, 1'b1);
      repeat (5) tick();
      chk("jmp_c5", {21'd0, s1}, {21'd0, ST_JMP});
      tick();
      chk("jmp_c6", {21'd0, s1}, {21'd0, ST_FADDR});
      chk("jmp_retired", {24'd0, d1_retired}, 32'd1);

      // HLT held with run toggling
      do_reset(4'b1111, 1'b1);
      repeat (4) tick();
      chk("hlt_c4_halted", {31'd0, d1_halted}, 32'd0);
      tick();
      chk("hlt_c5_halted", {31'd0, d1_halted}, 32'd1);
      chk("hlt_retired", {24'd0, d1_retired}, 32'd1);
      hcnt = 0;
      sor = 11'd0;
      for (int i = 0; i < 50; i++) begin
         run = i[0];
         tick();
         hcnt += int'(d1_halted);
         sor = sor | s1;
      end
      chk("hlt_held", hcnt, 32'd50);
      chk("hlt_no_strobes", {21'd0, sor}, 32'd0);

      // Illegal opcode, sticky across a following LDA, then reset mid-LDA
      do_reset(4'b0110, 1'b1);
      repeat (4) tick();
      chk("ill_c4", {31'd0, d1_illegal}, 32'd0);
      tick();
      chk("ill_c5_flag", {31'd0, d1_illegal}, 32'd1);
      chk("ill_c5_retired", {24'd0, d1_retired}, 32'd1);
      chk("ill_c5_fetch", {21'd0, s1}, {21'd0, ST_FADDR});
      opcode = 4'b1000;
      repeat (7) tick();
      chk("ill_sticky", {31'd0, d1_illegal}, 32'd1);
      chk("ill_retired2", {24'd0, d1_retired}, 32'd2);
      tick();
      tick();
      chk("mid_c3", {21'd0, s1}, {21'd0, ST_FIR});
      reset = 1'b1;
      tick();
      chk("mid_rst_strobes", {21'd0, s1}, 32'd0);
      chk("mid_rst_illegal", {31'd0, d1_illegal}, 32'd0);
      chk("mid_rst_retired", {24'd0, d1_retired}, 32'd0);
      tick();
      chk("mid_rst_hold", {21'd0, s1}, 32'd0);
      reset = 1'b0;

      // run dropped mid-instruction takes effect only at the boundary
      do_reset(4'b1000, 1'b1);
      tick();
      tick();
      run = 1'b0;
      repeat (5) tick();
      chk("run0_c7", {21'd0, s1}, {21'd0, ST_ALOAD});
      por = 1'b0;
      repeat (6) begin
         tick();
         por = por | d1_pc_out;
      end
      chk("run0_idle", {31'd0, por}, 32'd0);
      run = 1'b1;
      tick();
      chk("run1_fetch", {21'd0, s1}, {21'd0, ST_FADDR});

      // RAM_LAT=3 instance: ram_rd on cycles 2-4 and 8-10
      do_reset(4'b1000, 1'b1);
      rdv = 11'd0;
      for (int i = 0; i < 11; i++) begin
         tick();
         rdv[i] = d3_ram_rd;
      end
      chk("lat3_ram_rd", {21'd0, rdv}, 32'd910);
      chk("lat3_a_load", {31'd0, d3_a_load}, 32'd1);
      tick();
      chk("lat3_next_fetch", {31'd0, d3_pc_out}, 32'd1);

      // 256 four-cycle illegal instructions wrap retired
      do_reset(4'b0000, 1'b1);
      repeat (1024) tick();
      chk("wrap_255", {24'd0, d1_retired}, 32'd255);
      tick();
      chk("wrap_0", {24'd0, d1_retired}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
